uart_tx_prescaled: RTL and testbench

UART transmit path that pairs with the existing oversampling receiver. It accepts one parallel byte per handshake and serialises it onto TX_OUT. Frame: start bit (0), data bits LSB-first, optional parity, stop bit (1). Each bit lasts exactly Prescale CLK cycles, so TX and RX run from the same system clock and Prescale setting. It sits between the system-side data source (register file or FIFO read side) and the serial pin.

---
 rtl/uart_tx_prescaled.sv | 149 ++++++++++++++
 tb/tb_uart_tx_prescaled.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_prescaled.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit.
// Every bit lasts Prescale CLK cycles; Prescale values 0 and 1 run as 2.
`timescale 1ns/1ps

module uart_tx_prescaled #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      DATA_VALID,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      Busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                      state_q, state_d;
    logic [PRESCALE_WIDTH-1:0]   cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0]   last_q, last_d;
    logic [BIT_W-1:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0]       shift_q, shift_d;
    logic                        par_en_q, par_en_d;
    logic                        par_bit_q, par_bit_d;
    logic                        tx_q, tx_d;
    logic                        busy_q, busy_d;

    logic [PRESCALE_WIDTH-1:0]   presc_last;
    logic                        terminal;
    logic                        accept;

    // Terminal count of the latched bit period; illegal 0/1 collapse to a 2-cycle bit.
    assign presc_last = (Prescale < PRESCALE_WIDTH'(2)) ? PRESCALE_WIDTH'(1)
                                                        : Prescale - PRESCALE_WIDTH'(1);
    assign terminal   = (cnt_q == last_q);
    assign accept     = DATA_VALID && ((state_q == IDLE) || ((state_q == STOP) && terminal));

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = terminal ? '0 : cnt_q + PRESCALE_WIDTH'(1);
        last_d    = last_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
            START: begin
                if (terminal) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (terminal) begin
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                        tx_d    = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (terminal) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (terminal) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Acceptance overrides both IDLE and the final STOP cycle, giving gapless back-to-back frames.
        if (accept) begin
            state_d   = START;
            cnt_d     = '0;
            last_d    = presc_last;
            bit_d     = '0;
            shift_d   = P_DATA;
            par_en_d  = PAR_EN;
            par_bit_d = (^P_DATA) ^ PAR_TYP;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_prescaled.sv
// Self-checking bench: per-cycle line model plus a mid-bit sampling receiver model.
`timescale 1ns/1ps

module tb_uart_tx_prescaled;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [4:0] Prescale;
    logic       TX_OUT;
    logic       Busy;

    int tests = 0;
    int fails = 0;

    logic obs_q[$];
    logic bsy_q[$];

    uart_tx_prescaled #(.DATA_WIDTH(8), .PRESCALE_WIDTH(5)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescale(Prescale),
        .TX_OUT(TX_OUT), .Busy(Busy)
    );

    always #2.5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    function automatic logic sample(input int idx);
        return (idx < obs_q.size()) ? obs_q[idx] : 1'bx;
    endfunction

    // Drive a request while idle; returns #1 after the acceptance edge with the request dropped
    // and all inputs scrambled, so any leak of post-acceptance inputs corrupts the frame.
    task automatic drive_accept(input logic [7:0] d, input bit pe, input bit pt, input int p);
        @(posedge CLK); #1;
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = 5'(p); DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        DATA_VALID = 1'b0;
        P_DATA     = 8'($urandom);
        PAR_EN     = 1'($urandom);
        PAR_TYP    = 1'($urandom);
        Prescale   = 5'($urandom);
    endtask

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            obs_q.push_back(TX_OUT);
            bsy_q.push_back(Busy);
        end
    endtask

    // Line model: ideal bit list expanded to eff(p) cycles per bit, then a receiver
    // that samples each bit in its middle and checks data, parity and framing.
    task automatic check_frame(input string tag, input int off, input logic [7:0] d,
                               input bit pe, input bit pt, input int p);
        logic bits[$];
        int   e;
        int   mism;
        int   first;
        logic [7:0] rx;
        logic rs, rp, rstop;
        e = eff(p);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ pt);
        bits.push_back(1'b1);
        mism  = 0;
        first = -1;
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < e; c++) begin
                if (sample(off + b * e + c) !== bits[b]) begin
                    mism++;
                    if (first < 0) first = b * e + c;
                end
            end
        end
        check({tag, ".wave_mismatches"}, mism, 0);
        if (mism != 0) $display("  %s first bad cycle %0d", tag, first);
        rs = sample(off + e / 2);
        for (int i = 0; i < 8; i++) rx[i] = sample(off + (1 + i) * e + e / 2);
        rp    = pe ? sample(off + 9 * e + e / 2) : 1'b0;
        rstop = sample(off + (9 + int'(pe)) * e + e / 2);
        check({tag, ".rx_data"}, rx, d);
        check({tag, ".rx_frame_err"}, (rs !== 1'b0) || (rstop !== 1'b1), 0);
        check({tag, ".rx_parity_err"}, pe && (rp !== ((^rx) ^ pt)), 0);
    endtask

    task automatic check_busy(input string tag);
        int lows;
        lows = 0;
        foreach (bsy_q[i]) if (bsy_q[i] !== 1'b1) lows++;
        check({tag, ".busy_low_cycles"}, lows, 0);
    endtask

    task automatic check_idle(input string tag);
        @(negedge CLK);
        check({tag, ".idle_tx"}, TX_OUT, 1);
        check({tag, ".idle_busy"}, Busy, 0);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input bit pe,
                             input bit pt, input int p);
        obs_q.delete();
        bsy_q.delete();
        drive_accept(d, pe, pt, p);
        capture((10 + int'(pe)) * eff(p));
        check_frame(tag, 0, d, pe, pt, p);
        check_busy(tag);
        check_idle(tag);
    endtask

    initial begin
        RST = 1'b1; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 5'd8;
        #1;
        check("reset_tx", TX_OUT, 1);
        check("reset_busy", Busy, 0);
        #19;
        RST = 1'b0;
        check_idle("after_reset");

        run_frame("odd_af", 8'hAF, 1'b1, 1'b1, 8);
        run_frame("even_ad", 8'hAD, 1'b1, 1'b0, 8);
        run_frame("nopar_a5", 8'hA5, 1'b0, 1'b0, 8);

        // Reset during the data phase must release the line before the next clock edge.
        drive_accept(8'h5A, 1'b1, 1'b0, 8);
        repeat (3 * 8) @(negedge CLK);
        check("midrst.busy_before", Busy, 1);
        #1 RST = 1'b1;
        #1;
        check("midrst.tx_async", TX_OUT, 1);
        check("midrst.busy_async", Busy, 0);
        @(negedge CLK);
        RST = 1'b0;
        check_idle("midrst");
        run_frame("post_reset_frame", 8'h96, 1'b1, 1'b1, 8);

        // Back-to-back with request held; the pending byte changes while frame 1 is on the line.
        obs_q.delete();
        bsy_q.delete();
        @(posedge CLK); #1;
        P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 5'd8; DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        P_DATA = 8'hC3; PAR_TYP = 1'b1;
        capture(88);
        @(posedge CLK); #1;
        DATA_VALID = 1'b0; P_DATA = 8'($urandom); Prescale = 5'($urandom);
        capture(88);
        check_frame("b2b_first", 0, 8'h3C, 1'b1, 1'b0, 8);
        check_frame("b2b_second", 88, 8'hC3, 1'b1, 1'b1, 8);
        check_busy("b2b");
        check_idle("b2b");

        run_frame("presc0", 8'($urandom), 1'b1, 1'($urandom), 0);
        run_frame("presc1", 8'($urandom), 1'b0, 1'b0, 1);
        run_frame("presc2", 8'($urandom), 1'b1, 1'($urandom), 2);

        for (int i = 0; i < 20; i++) begin
            run_frame((i < 10) ? "sweep16" : "sweep31", 8'($urandom), 1'b1,
                      1'($urandom_range(0, 1)), (i < 10) ? 16 : 31);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
